mem_access_unit: RTL and testbench
==================================

# mem_access_unit

- Memory access stage for the LC-3 datapath.
- Directly downstream of the effective-address adder: registers the 16-bit effective address into MAR and data into MDR.
- Runs a single read or write transaction against a ready-handshaked memory port, then signals completion to the control FSM.
- Read data is returned on `mdrOut` for the bus and the IR/register-file loaders.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15: cycles in an access state without `memReady` before abort. Used only with `MEM_TIMEOUT_EN`. Legal range 1–255.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- eabOut  input  16  effective address from the EAB.
- busIn  input  16  datapath bus value, loaded into MDR for stores.
- ldMAR  input  1  load MAR from `eabOut`.
- ldMDR  input  1  load MDR from `busIn`.
- req  input  1  start an access; sampled only in IDLE.
- rw  input  1  access type, sampled with `req`: 1 = write, 0 = read.
- memReady  input  1  memory has completed the current access.
- memDataIn  input  16  read data from memory.
- memAddr  output  16  current MAR value.
- memDataOut  output  16  current MDR value.
- memEn  output  1  access strobe.
- memWe  output  1  write strobe.
- mdrOut  output  16  MDR contents.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  timeout flag; constant 0 without `MEM_TIMEOUT_EN`.

## Operation
- States: IDLE, READ, WRITE, DONE.
  - IDLE: `req`=1 moves to WRITE if `rw`=1, otherwise to READ.
  - READ: `memEn`=1. On `memReady`=1, MDR ← `memDataIn`, then go to DONE.
  - WRITE: `memEn`=1, `memWe`=1. On `memReady`=1, go to DONE.
  - DONE: `done`=1, then return to IDLE unconditionally.
- MAR/MDR loads:
  - `ldMAR`/`ldMDR` take effect only in IDLE; ignored while `busy`.
  - `ldMAR` or `ldMDR` asserted in the same cycle as `req` loads the register at that edge. The access uses the new value.
- `req` outside IDLE is ignored. No queuing.
- `memAddr`, `memDataOut` and `mdrOut` are direct register outputs. They stay stable for the whole access.
- `memEn` and `memWe` are decoded from state registers only, so they are glitch-free with respect to inputs.
- Arithmetic: 16-bit registers, no width conversion. The timeout counter is 8 bits.

## Timing
- Reset: state IDLE; MAR=0x0000, MDR=0x0000; `memEn`, `memWe`, `busy`, `done`, `err` all 0.
- Reset mid-access abandons the transaction. `memEn`/`memWe` are low in the cycle after reset is sampled, and no `done` is issued.
- Latency from `req` sampled at edge 0:
  - `memEn` is high after edge 0.
  - If `memReady`=1 in that first cycle, `done` pulses after edge 1, and read data is in MDR at that same time.
  - Each cycle of `memReady`=0 adds one cycle.
- Back-to-back accesses: after the DONE cycle returns to IDLE, a new `req` needs at least 1 IDLE cycle. Minimum period is 3 cycles per access.
- `memReady` is ignored in IDLE and DONE.

## Configuration
- Macro `MEM_TIMEOUT_EN`. When defined:
  - An 8-bit counter clears on entry to READ/WRITE and increments each cycle with `memReady`=0.
  - On reaching TIMEOUT_CYCLES, the FSM goes to DONE with `err`=1. A read timeout leaves MDR unchanged.
  - `err` is sticky until the next accepted `req` or `rst`.
  - `memReady` arriving in the same cycle the count hits the limit counts as success, not timeout.
- When not defined:
  - No counter is built; READ/WRITE wait indefinitely.
  - `err` is tied to 0.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, `memAddr`=0x0000.
- Read with zero wait states:
  - Stimulus: `ldMAR` with `eabOut`=0x3005, then `req`, `rw`=0; memory returns 0xBEEF with `memReady` high immediately.
  - Response: `memEn` for 1 cycle, `memAddr`=0x3005, `done` 2 cycles after `req`, `mdrOut`=0xBEEF.
- Write with 3 wait states:
  - Stimulus: `ldMDR` with `busIn`=0x1234 and `ldMAR` with `eabOut`=0xFE00 in the same cycle as `req`, `rw`=1.
  - Response: `memWe`/`memEn` high 4 cycles, `memDataOut`=0x1234, a single `done` pulse, `busy` low afterwards.
- Interference during access: `ldMAR`=1 with `eabOut`=0x0000 and `req`=1 mid-read → `memAddr` unchanged, no second access started.
- Reset in the 2nd wait cycle of a read → `memEn`=0 and `busy`=0 the next cycle, MAR=MDR=0, no `done`.
- With `MEM_TIMEOUT_EN`:
  - TIMEOUT_CYCLES=4 and `memReady` held low → `done` and `err`=1 after 4 access cycles, MDR unchanged; next `req` clears `err`.
  - `memReady` on the 4th cycle → `err`=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// LC-3 memory access stage: MAR/MDR registers plus a single-transaction read/write FSM.
// Optional abort-on-timeout is built only when MEM_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] eabOut,
  input  logic [15:0] busIn,
  input  logic        ldMAR,
  input  logic        ldMDR,
  input  logic        req,
  input  logic        rw,
  input  logic        memReady,
  input  logic [15:0] memDataIn,
  output logic [15:0] memAddr,
  output logic [15:0] memDataOut,
  output logic        memEn,
  output logic        memWe,
  output logic [15:0] mdrOut,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, stateNext;
  logic [15:0] mar, mdr;
  logic        accepted;
  logic        inAccess;
  logic        timeoutHit;

  // Handshake: memEn is held high for the whole access; the transfer completes
  // in the first cycle where memEn && memReady, and memReady is ignored otherwise.
  assign accepted = (state == IDLE) && req;
  assign inAccess = (state == READ) || (state == WRITE);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] waitCnt;
  logic       errReg;

  // Hit is evaluated only when memReady is low, so a late ready still wins.
  assign timeoutHit = inAccess && !memReady && (waitCnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= 8'd0;
      errReg  <= 1'b0;
    end else begin
      if (accepted) begin
        waitCnt <= 8'd0;
        errReg  <= 1'b0;
      end else if (inAccess && !memReady) begin
        waitCnt <= waitCnt + 8'd1;
      end
      if (timeoutHit) errReg <= 1'b1;
    end
  end

  assign err = errReg;
`else
  assign timeoutHit = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req) stateNext = rw ? WRITE : READ;
      READ:    if (memReady || timeoutHit) stateNext = DONE;
      WRITE:   if (memReady || timeoutHit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Loads are honoured only in IDLE so the address/data stay frozen during an access.
  always_ff @(posedge clk) begin
    if (rst) begin
      mar <= 16'h0000;
      mdr <= 16'h0000;
    end else begin
      if (state == IDLE && ldMAR) mar <= eabOut;
      if (state == IDLE && ldMDR) mdr <= busIn;
      else if (state == READ && memReady) mdr <= memDataIn;
    end
  end

  assign memAddr    = mar;
  assign memDataOut = mdr;
  assign mdrOut     = mdr;
  assign memEn      = inAccess;
  assign memWe      = (state == WRITE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; timeout scenarios are compiled in with MEM_TIMEOUT_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] eabOut, busIn, memDataIn;
  logic        ldMAR, ldMDR, req, rw, memReady;
  logic [15:0] memAddr, memDataOut, mdrOut;
  logic        memEn, memWe, busy, done, err;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .eabOut(eabOut), .busIn(busIn), .ldMAR(ldMAR),
    .ldMDR(ldMDR), .req(req), .rw(rw), .memReady(memReady), .memDataIn(memDataIn),
    .memAddr(memAddr), .memDataOut(memDataOut), .memEn(memEn), .memWe(memWe),
    .mdrOut(mdrOut), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are checked 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ldMAR = 0; ldMDR = 0; req = 0; rw = 0; memReady = 0;
  endtask

  task automatic test_reset();
    rst = 1; eabOut = 0; busIn = 0; memDataIn = 0;
    idle_inputs();
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({memEn, memWe, busy, done, err, memAddr, memDataOut, mdrOut} !== 53'd0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: en=%b we=%b busy=%b done=%b err=%b addr=%h mdr=%h expected all 0",
                 i, memEn, memWe, busy, done, err, memAddr, mdrOut);
      end
    end
  endtask

  task automatic test_read_zero_wait();
    ldMAR = 1; eabOut = 16'h3005;
    tick();
    ldMAR = 0; req = 1; rw = 0; memReady = 1; memDataIn = 16'hBEEF;
    tick();
    req = 0;
    total++;
    if ({memEn, memWe, busy, done, memAddr} !== {4'b1010, 16'h3005}) begin
      bad++;
      $display("FAIL read0_access: en=%b we=%b busy=%b done=%b addr=%h expected 1 0 1 0 3005",
               memEn, memWe, busy, done, memAddr);
    end
    tick();
    memReady = 0;
    total++;
    if ({done, memEn, mdrOut} !== {2'b10, 16'hBEEF}) begin
      bad++;
      $display("FAIL read0_done: done=%b en=%b mdr=%h expected 1 0 beef", done, memEn, mdrOut);
    end
    tick();
    total++;
    if ({done, busy, mdrOut} !== {2'b00, 16'hBEEF}) begin
      bad++;
      $display("FAIL read0_after: done=%b busy=%b mdr=%h expected 0 0 beef", done, busy, mdrOut);
    end
  endtask

  task automatic test_write_wait3();
    ldMDR = 1; busIn = 16'h1234; ldMAR = 1; eabOut = 16'hFE00; req = 1; rw = 1; memReady = 0;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({memEn, memWe, done, memAddr, memDataOut} !== {3'b110, 16'hFE00, 16'h1234}) begin
        bad++;
        $display("FAIL write3_cycle%0d: en=%b we=%b done=%b addr=%h data=%h expected 1 1 0 fe00 1234",
                 i, memEn, memWe, done, memAddr, memDataOut);
      end
      if (i == 3) memReady = 1;
      tick();
    end
    memReady = 0;
    total++;
    if ({done, memEn, memWe, busy} !== 4'b1001) begin
      bad++;
      $display("FAIL write3_done: done=%b en=%b we=%b busy=%b expected 1 0 0 1", done, memEn, memWe, busy);
    end
    tick();
    total++;
    if ({done, busy, memEn} !== 3'b000) begin
      bad++;
      $display("FAIL write3_after: done=%b busy=%b en=%b expected 0 0 0", done, busy, memEn);
    end
  endtask

  task automatic test_interference();
    ldMAR = 1; eabOut = 16'h4000;
    tick();
    ldMAR = 0; req = 1; rw = 0;
    tick();
    ldMAR = 1; eabOut = 16'h0000; req = 1; rw = 1;
    tick();
    total++;
    if ({memEn, memWe, memAddr} !== {2'b10, 16'h4000}) begin
      bad++;
      $display("FAIL interf_mid: en=%b we=%b addr=%h expected 1 0 4000", memEn, memWe, memAddr);
    end
    idle_inputs(); memReady = 1; memDataIn = 16'h5A5A;
    tick();
    memReady = 0;
    total++;
    if ({done, memAddr, mdrOut} !== {1'b1, 16'h4000, 16'h5A5A}) begin
      bad++;
      $display("FAIL interf_done: done=%b addr=%h mdr=%h expected 1 4000 5a5a", done, memAddr, mdrOut);
    end
    tick(); tick();
    total++;
    if ({busy, memEn, done} !== 3'b000) begin
      bad++;
      $display("FAIL interf_no_second: busy=%b en=%b done=%b expected 0 0 0", busy, memEn, done);
    end
  endtask

  task automatic test_reset_mid_read();
    ldMAR = 1; eabOut = 16'h2222; ldMDR = 1; busIn = 16'h7777; req = 1; rw = 0;
    tick();
    idle_inputs();
    tick();
    rst = 1;
    tick();
    rst = 0;
    total++;
    if ({memEn, busy, done, memAddr, mdrOut} !== 35'd0) begin
      bad++;
      $display("FAIL rst_mid: en=%b busy=%b done=%b addr=%h mdr=%h expected 0 0 0 0000 0000",
               memEn, busy, done, memAddr, mdrOut);
    end
    tick();
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_after: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    ldMAR = 1; eabOut = 16'h0100; ldMDR = 1; busIn = 16'hAAAA; req = 1; rw = 1; memReady = 1;
    tick();
    ldMAR = 0; ldMDR = 0;
    total++;
    if ({memWe, memAddr} !== {1'b1, 16'h0100}) begin
      bad++;
      $display("FAIL b2b_first: we=%b addr=%h expected 1 0100", memWe, memAddr);
    end
    ldMAR = 1; eabOut = 16'h0102;
    tick();
    total++;
    if ({done, busy} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_done1: done=%b busy=%b expected 1 1", done, busy);
    end
    tick();
    total++;
    if ({busy, memEn, memAddr} !== {2'b00, 16'h0100}) begin
      bad++;
      $display("FAIL b2b_idle: busy=%b en=%b addr=%h expected 0 0 0100", busy, memEn, memAddr);
    end
    tick();
    idle_inputs(); memReady = 1;
    total++;
    if ({memWe, memEn, memAddr, memDataOut} !== {2'b11, 16'h0102, 16'hAAAA}) begin
      bad++;
      $display("FAIL b2b_second: we=%b en=%b addr=%h data=%h expected 1 1 0102 aaaa",
               memWe, memEn, memAddr, memDataOut);
    end
    tick();
    memReady = 0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done2: done=%b expected 1", done);
    end
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    ldMAR = 1; eabOut = 16'h3000; ldMDR = 1; busIn = 16'h1111; req = 1; rw = 0; memReady = 0;
    tick();
    idle_inputs(); memDataIn = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({memEn, done, err} !== 3'b100) begin
        bad++;
        $display("FAIL to_wait%0d: en=%b done=%b err=%b expected 1 0 0", i, memEn, done, err);
      end
      tick();
    end
    total++;
    if ({done, err, mdrOut} !== {2'b11, 16'h1111}) begin
      bad++;
      $display("FAIL to_abort: done=%b err=%b mdr=%h expected 1 1 1111", done, err, mdrOut);
    end
    tick();
    total++;
    if ({done, busy, err} !== 3'b001) begin
      bad++;
      $display("FAIL to_sticky: done=%b busy=%b err=%b expected 0 0 1", done, busy, err);
    end
    req = 1; rw = 0; memReady = 1; memDataIn = 16'h2222;
    tick();
    req = 0;
    total++;
    if ({memEn, err} !== 2'b10) begin
      bad++;
      $display("FAIL to_clear: en=%b err=%b expected 1 0", memEn, err);
    end
    tick(); tick();
    req = 1; rw = 0; memReady = 0; memDataIn = 16'h3333;
    tick();
    req = 0;
    tick(); tick(); tick();
    memReady = 1;
    tick();
    memReady = 0;
    total++;
    if ({done, err, mdrOut} !== {2'b10, 16'h3333}) begin
      bad++;
      $display("FAIL to_late_ready: done=%b err=%b mdr=%h expected 1 0 3333", done, err, mdrOut);
    end
    tick();
  endtask
`else
  task automatic test_long_wait();
    req = 1; rw = 1; memReady = 0;
    tick();
    req = 0;
    for (int i = 0; i < 20; i++) tick();
    total++;
    if ({memEn, memWe, done, err} !== 4'b1100) begin
      bad++;
      $display("FAIL long_wait: en=%b we=%b done=%b err=%b expected 1 1 0 0", memEn, memWe, done, err);
    end
    memReady = 1;
    tick();
    memReady = 0;
    total++;
    if ({done, err} !== 2'b10) begin
      bad++;
      $display("FAIL long_wait_done: done=%b err=%b expected 1 0", done, err);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait3();
    test_interference();
    test_reset_mid_read();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
